// File: rtl/router_dest_rx.sv
// Destination-side receiver: drains one router output FIFO, re-frames packets onto a
// valid/ready stream with sop/eop, and reports address, parity and truncation errors.
module router_dest_rx #(
    parameter logic [1:0]  PORT_ID = 2'd0,
    parameter int unsigned TIMEOUT = 30
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       fifo_empty_i,
    output logic       fifo_rd_enb_o,
    input  logic [7:0] fifo_data_i,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic       m_sop_o,
    output logic       m_eop_o,
    output logic [5:0] pkt_len_o,
    output logic       pkt_done_o,
    output logic       parity_err_o,
    output logic       addr_err_o,
    output logic       trunc_err_o
);
    typedef enum logic [2:0] {IDLE, HDR, PAYLD, PARITY, DONE} state_e;
    typedef struct packed { logic [7:0] data; logic sop; logic eop; } beat_t;

    state_e     state_q, state_d;
    logic       inflight_q;
    logic [6:0] rem_rd_q, rem_rd_d;   // bytes of this packet still to be read (known so far)
    logic [5:0] rem_q, rem_d, len_q, len_d;
    logic [7:0] par_q, par_d, to_q, to_d;
    logic       drop_q, drop_d, par_err_q, par_err_d, trunc_q, trunc_d;
    beat_t      buf0_q, buf0_d, buf1_q, buf1_d, push_beat;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] occ;
    logic       rd, pop, push, more, counting, timeout;

    assign pop = (cnt_q != 2'd0) && m_ready_i;
    // Occupancy once this cycle's pop and the in-flight byte settle; a new read lands next cycle.
    assign occ = {1'b0, cnt_q} - {2'b0, pop} + {2'b0, inflight_q};
    assign more = (state_q == IDLE) ||
                  ((state_q != DONE) && (rem_rd_q != 7'd0));
    assign rd = !reset_i && !fifo_empty_i && (state_q != DONE) && (occ < 3'd2) && more;
    assign counting = ((state_q == PAYLD) || (state_q == PARITY)) && fifo_empty_i && !rd;
    assign timeout = counting && !inflight_q && (to_q >= 8'(TIMEOUT - 1));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            rem_rd_q   <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            par_q      <= '0;
            to_q       <= '0;
            drop_q     <= 1'b0;
            par_err_q  <= 1'b0;
            trunc_q    <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd;
            rem_rd_q   <= rem_rd_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            par_q      <= par_d;
            to_q       <= to_d;
            drop_q     <= drop_d;
            par_err_q  <= par_err_d;
            trunc_q    <= trunc_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_rd_d  = rem_rd_q - 7'(rd);
        rem_d     = rem_q;
        len_d     = len_q;
        par_d     = par_q;
        drop_d    = drop_q;
        par_err_d = par_err_q;
        trunc_d   = trunc_q;
        push      = 1'b0;
        push_beat = '0;
        to_d      = '0;
        if (counting && !rd)
            to_d = (to_q == 8'hFF) ? to_q : to_q + 8'd1;
        case (state_q)
            IDLE: if (rd) begin
                state_d  = HDR;
                rem_rd_d = 7'd1;   // at least the parity byte follows the header
            end
            HDR: if (inflight_q) begin
                len_d     = fifo_data_i[7:2];
                rem_d     = fifo_data_i[7:2];
                par_d     = fifo_data_i;
                drop_d    = (fifo_data_i[1:0] != PORT_ID);
                par_err_d = 1'b0;
                trunc_d   = 1'b0;
                rem_rd_d  = rem_rd_q - 7'(rd) + {1'b0, fifo_data_i[7:2]};
                push      = (fifo_data_i[1:0] == PORT_ID);
                push_beat = '{data: fifo_data_i, sop: 1'b1, eop: (fifo_data_i[7:2] == 6'd0)};
                state_d   = (fifo_data_i[7:2] == 6'd0) ? PARITY : PAYLD;
            end
            PAYLD: if (inflight_q) begin
                par_d     = par_q ^ fifo_data_i;
                rem_d     = rem_q - 6'd1;
                push      = !drop_q;
                push_beat = '{data: fifo_data_i, sop: 1'b0, eop: (rem_q == 6'd1)};
                if (rem_q == 6'd1) state_d = PARITY;
            end else if (timeout) begin
                trunc_d = 1'b1;
                state_d = DONE;
            end
            PARITY: if (inflight_q) begin
                par_err_d = (par_q != fifo_data_i);
                state_d   = DONE;
            end else if (timeout) begin
                trunc_d = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) buf0_d = push_beat;
                else               buf1_d = push_beat;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) buf0_d = push_beat;
                else begin
                    buf0_d = buf1_q;
                    buf1_d = push_beat;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        fifo_rd_enb_o = rd;
        m_valid_o     = (cnt_q != 2'd0);
        m_data_o      = buf0_q.data;
        m_sop_o       = m_valid_o && buf0_q.sop;
        m_eop_o       = m_valid_o && buf0_q.eop;
        pkt_len_o     = len_q;
        pkt_done_o    = (state_q == DONE);
        parity_err_o  = pkt_done_o && par_err_q;
        addr_err_o    = pkt_done_o && drop_q;
        trunc_err_o   = pkt_done_o && trunc_q;
    end
endmodule
